rand_sq_stim: RTL

RAND_SQ_STIM -- requirements
Module: rand_sq_stim

---
 rtl/rand_sq_stim.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rand_sq_stim.sv
// rand_sq_stim: takes random words from an upstream generator and issues them as
// stimulus to a squarer, one vector at a time. It collects each result into an
// XOR checksum and counts the results received. If no result arrives within
// TIMEOUT cycles, the run aborts and a sticky error flag is set.
//
// Ports
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset
//   start       - one-cycle pulse; begins a run from IDLE or DONE
//   rand_in     - free-running random word (N bits)
//   sq_valid    - stimulus valid to squarer
//   sq_ready    - squarer accepts stimulus
//   sq_data     - stimulus word (N bits)
//   res_valid   - one-cycle result strobe from squarer
//   res_data    - result word (N bits)
//   busy        - run in progress (LOAD/SEND/WAIT)
//   done        - run finished or aborted
//   timeout_err - sticky: a result wait expired
//   vec_count   - results received this run
//   checksum    - XOR of all results received this run
module rand_sq_stim #(
    parameter int unsigned N           = 1024,
    parameter int unsigned VALUE_BITS  = 1024,
    parameter int unsigned NUM_VECTORS = 16,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [N-1:0]                       rand_in,
    output logic                               sq_valid,
    input  logic                               sq_ready,
    output logic [N-1:0]                       sq_data,
    input  logic                               res_valid,
    input  logic [N-1:0]                       res_data,
    output logic                               busy,
    output logic                               done,
    output logic                               timeout_err,
    output logic [$clog2(NUM_VECTORS+1)-1:0]   vec_count,
    output logic [N-1:0]                       checksum
);

    localparam int unsigned CntW = $clog2(NUM_VECTORS + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    // Keeps only the VALUE_BITS low bits of each random word.
    localparam logic [N-1:0] ValueMask = {N{1'b1}} >> (N - VALUE_BITS);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSend,
        StWait,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      stim_q, stim_d;
    logic [CntW-1:0]   vec_q, vec_d;
    logic [N-1:0]      csum_q, csum_d;
    logic              terr_q, terr_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [N-1:0]      masked;
    logic [CntW-1:0]   vec_inc;

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        vec_d   = vec_q;
        csum_d  = csum_q;
        terr_d  = terr_q;
        tmo_d   = tmo_q;
        masked  = rand_in & ValueMask;
        vec_inc = vec_q + 1'b1;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    vec_d   = '0;
                    csum_d  = '0;
                    terr_d  = 1'b0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                // A zero stimulus is never issued; substitute 1.
                stim_d  = (masked == '0) ? N'(1) : masked;
                state_d = StSend;
            end
            StSend: begin
                if (sq_ready) begin
                    tmo_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                // A result on the expiry cycle wins over the timeout.
                if (res_valid) begin
                    csum_d  = csum_q ^ res_data;
                    vec_d   = vec_inc;
                    state_d = (vec_inc == CntW'(NUM_VECTORS)) ? StDone : StLoad;
                end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            stim_q  <= '0;
            vec_q   <= '0;
            csum_q  <= '0;
            terr_q  <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            vec_q   <= vec_d;
            csum_q  <= csum_d;
            terr_q  <= terr_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        sq_valid    = (state_q == StSend);
        busy        = (state_q == StLoad) || (state_q == StSend) || (state_q == StWait);
        done        = (state_q == StDone);
        sq_data     = stim_q;
        timeout_err = terr_q;
        vec_count   = vec_q;
        checksum    = csum_q;
    end

endmodule
